st7735_spi_master: RTL



---
 rtl/st7735_pkg.sv | 18 +
 rtl/st7735_spi_master.sv | 132 +++++++++++++
 2 files changed

// File: rtl/st7735_pkg.sv
// Shared definitions for the ST7735 display path: serialiser state encoding,
// byte width and the panel command opcodes the controller issues.
package st7735_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } spi_state_t;

  localparam int SPI_BITS = 8;

  // ST7735 command opcodes (column/row address set, memory write)
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

endpackage

// File: rtl/st7735_spi_master.sv
// SPI mode-0 byte transmitter for the ST7735 panel. Serialises one byte
// MSB first on tft_sck/tft_mosi per accepted spi_start. All outputs are
// registered; the divider is inline so a byte takes exactly 16*CLK_DIV cycles.
module st7735_spi_master
  import st7735_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int CLK_DIV    = 4,
  parameter int SCK_MAX_HZ = 15_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_start,
  input  logic [7:0] spi_data,
  output logic       spi_busy,
  output logic       spi_done,
  output logic       tft_sck,
  output logic       tft_mosi
);

  localparam int DIV_W  = ($clog2(CLK_DIV + 1) < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam int SCK_HZ = CLK_HZ / (2 * ((CLK_DIV > 0) ? CLK_DIV : 1));
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]       BIT_LAST = 3'(SPI_BITS - 1);

  // Reject divider settings that are out of range or overclock the panel
  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
    $fatal(1, "st7735_spi_master: CLK_DIV must be 1..255");
  end
  if (SCK_HZ > SCK_MAX_HZ) begin : g_bad_rate
    $fatal(1, "st7735_spi_master: SCK rate exceeds SCK_MAX_HZ");
  end

  spi_state_t          state_q, state_d;
  logic [SPI_BITS-1:0] shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state logic: idle/load, SCK low half, SCK high half
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        sck_d  = 1'b0;
        if (spi_start) begin
          shift_d   = spi_data;
          mosi_d    = spi_data[SPI_BITS-1];
          bit_cnt_d = '0;
          div_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = S_LO;
        end
      end
      S_LO: begin
        sck_d = 1'b0;
        if (div_cnt_q == DIV_LAST) begin
          sck_d     = 1'b1;
          div_cnt_d = '0;
          state_d   = S_HI;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      S_HI: begin
        sck_d = 1'b1;
        if (div_cnt_q == DIV_LAST) begin
          sck_d     = 1'b0;
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            // Last bit sampled; MOSI holds its value into idle
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            shift_d   = {shift_q[SPI_BITS-2:0], 1'b0};
            mosi_d    = shift_q[SPI_BITS-2];
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = S_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        sck_d   = 1'b0;
      end
    endcase
  end

  // State registers; async reset drops SCK/MOSI/busy immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign spi_busy = busy_q;
  assign spi_done = done_q;
  assign tft_sck  = sck_q;
  assign tft_mosi = mosi_q;

endmodule
